// File: rtl/accel_seq_pkg.sv
// Shared types and constants for the accelerator job sequencer.
//   state_t  : sequencer FSM states (IDLE, LAUNCH, WAIT)
//   DATA_W   : operand / result width
//   wd_width : watchdog counter width for a given TIMEOUT
package accel_seq_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  // The watchdog must be able to hold the value TIMEOUT itself.
  function automatic int wd_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/accel_sequencer_if.sv
// Bundle of the sequencer's operand input, accelerator and result ports.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits for ready, and the producer holds valid and
// data steady until the transfer happens.
//   in_*     : operand pair stream into the FIFO (in_ready_o = FIFO not full)
//   acc_*    : start/busy interface to the root accelerator
//   out_*    : result register (out_err_o marks a watchdog abort)
//   count_o  : FIFO occupancy
//   dbg_state: current sequencer FSM state
// Modport slave is the sequencer side, master is the environment side.
interface accel_seq_if #(parameter int DEPTH = 4);
  import accel_seq_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_a_i;
  logic [DATA_W-1:0] in_b_i;
  logic              acc_start_o;
  logic [DATA_W-1:0] acc_a_o;
  logic [DATA_W-1:0] acc_b_o;
  logic              acc_busy_i;
  logic [DATA_W-1:0] acc_y_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_y_o;
  logic              out_err_o;
  logic [CW-1:0]     count_o;
  state_t            dbg_state;

  modport slave (
    input  in_valid_i, in_a_i, in_b_i, acc_busy_i, acc_y_i, out_ready_i,
    output in_ready_o, acc_start_o, acc_a_o, acc_b_o,
           out_valid_o, out_y_o, out_err_o, count_o, dbg_state
  );

  modport master (
    output in_valid_i, in_a_i, in_b_i, acc_busy_i, acc_y_i, out_ready_i,
    input  in_ready_o, acc_start_o, acc_a_o, acc_b_o,
           out_valid_o, out_y_o, out_err_o, count_o, dbg_state
  );

endinterface

// File: rtl/accel_op_fifo.sv
// Operand FIFO: DEPTH entries of WIDTH bits, first-word fall-through.
//   push_i/pop_i : write / read strobes (ignored when full / empty)
//   din_i/dout_o : write data / head entry
//   full_o, empty_o, count_o : status and occupancy
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module accel_op_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) wr_q <= wr_q + PTR_ONE;
      if (pop_i && !empty_o) rd_q <= rd_q + PTR_ONE;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem[wr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = mem[rd_q[AW-1:0]];
  assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign empty_o = (wr_q == rd_q);
  assign count_o = wr_q - rd_q;

endmodule

// File: rtl/accel_sequencer.sv
// Job sequencer in front of the 8-bit root accelerator. Buffers (a, b)
// pairs, launches one job at a time with a one-cycle start pulse, waits for
// busy to fall (or the watchdog to expire) and holds the result in a
// valid/ready output register.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   bus          : operand, accelerator and result signals (slave side)
module accel_sequencer
  import accel_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk_i,
  input  logic        rst_i,
  accel_seq_if.slave  bus
);

  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int WD_W = wd_width(TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

  state_t              state_q, state_d;
  logic                start_q, start_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, y_q, y_d;
  logic                valid_q, valid_d, err_q, err_d;
  logic [WD_W-1:0]     wd_q, wd_d;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2*DATA_W-1:0] fifo_head;
  logic [CW-1:0]       fifo_count;
  logic                slot_free;

  assign fifo_push = bus.in_valid_i & ~fifo_full;

  accel_op_fifo #(.DEPTH(DEPTH), .WIDTH(2 * DATA_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   ({bus.in_a_i, bus.in_b_i}),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    a_d       = a_q;
    b_d       = b_q;
    y_d       = y_q;
    err_d     = err_q;
    wd_d      = wd_q;
    fifo_pop  = 1'b0;
    // The slot frees up in the same cycle the current result is taken.
    slot_free = ~valid_q | bus.out_ready_i;
    valid_d   = valid_q & ~bus.out_ready_i;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          a_d      = fifo_head[2*DATA_W-1:DATA_W];
          b_d      = fifo_head[DATA_W-1:0];
          start_d  = 1'b1;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        // Busy is not meaningful yet; just arm the watchdog.
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (!bus.acc_busy_i) begin
          if (slot_free) begin
            y_d     = bus.acc_y_i;
            err_d   = 1'b0;
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end else if (wd_q == WD_MAX) begin
          // Watchdog expired: the counter stays saturated until the slot
          // frees, then whatever the accelerator shows is flagged as error.
          if (slot_free) begin
            y_d     = bus.acc_y_i;
            err_d   = 1'b1;
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end else begin
          wd_d = wd_q + WD_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready_o  = ~fifo_full;
  assign bus.acc_start_o = start_q;
  assign bus.acc_a_o     = a_q;
  assign bus.acc_b_o     = b_q;
  assign bus.out_valid_o = valid_q;
  assign bus.out_y_o     = y_q;
  assign bus.out_err_o   = err_q;
  assign bus.count_o     = fifo_count;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_accel_sequencer.sv
// Bench for accel_sequencer: accelerator stub with programmable busy time,
// scoreboard of expected results derived from the pushed operands, and
// directed scenarios followed by a randomized run.
module tb_accel_sequencer;
  import accel_seq_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 50;
  localparam logic [7:0] STUCK_Y = 8'hA5;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  accel_seq_if #(.DEPTH(DEPTH)) bus ();

  accel_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // ---------------- reference arithmetic ----------------
  function automatic int icbrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic logic [7:0] root_f(input logic [7:0] a, input logic [7:0] b);
    return 8'(isqrt(int'(a) + icbrt(int'(b))));
  endfunction

  // ---------------- check bookkeeping ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- accelerator stub ----------------
  int   stub_lat   = 3;      // 0 selects a random busy time of 1..6 cycles
  bit   stuck_mode = 1'b0;   // jobs launched while set never drop busy
  bit   stuck_job;
  int   rem;
  logic [7:0] pend_y;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rem       <= 0;
      stuck_job <= 1'b0;
    end else if (bus.acc_start_o) begin
      rem       <= (stub_lat == 0) ? int'($urandom_range(1, 6)) : stub_lat;
      stuck_job <= stuck_mode;
      pend_y    <= root_f(bus.acc_a_o, bus.acc_b_o);
      bus.acc_y_i <= stuck_mode ? STUCK_Y : 8'($urandom);
    end else if (rem != 0) begin
      rem <= rem - 1;
      if (!stuck_job) bus.acc_y_i <= (rem == 1) ? pend_y : 8'($urandom);
    end
  end

  assign bus.acc_busy_i = bus.acc_start_o | (rem != 0) | stuck_job;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [7:0] y;
    logic       err;
  } res_t;

  res_t        exp_q[$];
  logic [15:0] op_q[$];
  logic [7:0]  got_q[$];
  int   pushes, starts, max_count;
  bit   saw_full, prev_start, prev_hold, chk_en;
  logic [7:0] prev_y;
  logic       prev_err;

  task automatic model_flush();
    exp_q.delete();
    op_q.delete();
    pushes     = 0;
    starts     = 0;
    prev_start = 1'b0;
    prev_hold  = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (rst_i && chk_en) begin
      if (bus.acc_start_o) begin
        starts++;
        check("start_single_cycle", 32'(prev_start), 32'd0);
        check("launch_has_job", 32'(op_q.size() > 0), 32'd1);
        if (op_q.size() > 0) begin
          logic [15:0] ops;
          ops = op_q.pop_front();
          check("acc_a", 32'(bus.acc_a_o), 32'(ops[15:8]));
          check("acc_b", 32'(bus.acc_b_o), 32'(ops[7:0]));
        end
      end
      check("count", 32'(bus.count_o), 32'(pushes - starts));
      check("in_ready", 32'(bus.in_ready_o), 32'((pushes - starts) < DEPTH));
      if (int'(bus.count_o) > max_count) max_count = int'(bus.count_o);
      if (!bus.in_ready_o) saw_full = 1'b1;

      if (prev_hold) begin
        check("hold_valid", 32'(bus.out_valid_o), 32'd1);
        check("hold_y", 32'(bus.out_y_o), 32'(prev_y));
        check("hold_err", 32'(bus.out_err_o), 32'(prev_err));
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        check("result_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          res_t e;
          e = exp_q.pop_front();
          check("result_y", 32'(bus.out_y_o), 32'(e.y));
          check("result_err", 32'(bus.out_err_o), 32'(e.err));
        end
        got_q.push_back(bus.out_y_o);
      end
      prev_hold = bus.out_valid_o & ~bus.out_ready_i;
      prev_y    = bus.out_y_o;
      prev_err  = bus.out_err_o;

      if (bus.in_valid_i && bus.in_ready_o) begin
        pushes++;
        op_q.push_back({bus.in_a_i, bus.in_b_i});
        exp_q.push_back(stuck_mode ? {STUCK_Y, 1'b1} : {root_f(bus.in_a_i, bus.in_b_i), 1'b0});
      end
      prev_start = bus.acc_start_o;
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end at posedge + 1.
  task automatic push(input logic [7:0] a, input logic [7:0] b);
    bit acc;
    bit done;
    done = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.in_a_i     = a;
    bus.in_b_i     = b;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk_i);
      acc = bus.in_ready_o;
      @(posedge clk_i);
      #1;
      if (acc) done = 1'b1;
    end
    bus.in_valid_i = 1'b0;
    check("push_accepted", 32'(done), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() == 0 && !bus.out_valid_o) break;
    end
    check("drain_in_budget", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    static logic [7:0] burst_a[5] = '{8'd7, 8'd14, 8'd0, 8'd0, 8'd255};
    static logic [7:0] burst_b[5] = '{8'd8, 8'd8,  8'd27, 8'd0, 8'd0};
    static logic [7:0] burst_y[5] = '{8'd3, 8'd4,  8'd1, 8'd0, 8'd15};
    int n, s0, seen;
    bit found, push_done;

    bus.in_valid_i  = 1'b0;
    bus.in_a_i      = '0;
    bus.in_b_i      = '0;
    bus.out_ready_i = 1'b1;
    chk_en          = 1'b0;
    max_count       = 0;
    saw_full        = 1'b0;
    model_flush();

    // Pin the reference arithmetic to hand-computed values.
    for (int i = 0; i < 5; i++)
      check("model_root", 32'(root_f(burst_a[i], burst_b[i])), 32'(burst_y[i]));

    // Reset state.
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_start", 32'(bus.acc_start_o), 32'd0);
    check("rst_acc_a", 32'(bus.acc_a_o), 32'd0);
    check("rst_acc_b", 32'(bus.acc_b_o), 32'd0);
    check("rst_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_y", 32'(bus.out_y_o), 32'd0);
    check("rst_err", 32'(bus.out_err_o), 32'd0);
    check("rst_count", 32'(bus.count_o), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    rst_i  = 1'b1;
    chk_en = 1'b1;
    @(posedge clk_i);
    #1;

    // Single job: start pulse one cycle after the push edge.
    got_q.delete();
    push(8'd7, 8'd8);
    @(negedge clk_i);
    check("single_start_n1", 32'(bus.acc_start_o), 32'd0);
    @(negedge clk_i);
    check("single_start_n2", 32'(bus.acc_start_o), 32'd1);
    @(negedge clk_i);
    check("single_start_n3", 32'(bus.acc_start_o), 32'd0);
    @(posedge clk_i);
    #1;
    wait_drain(100);
    check("single_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) check("single_y", 32'(got_q[0]), 32'd3);

    // Burst of five, back to back.
    got_q.delete();
    max_count = 0;
    saw_full  = 1'b0;
    for (int i = 0; i < 5; i++) push(burst_a[i], burst_b[i]);
    wait_drain(200);
    check("burst_peak_count", 32'(max_count), 32'd4);
    check("burst_in_ready_dropped", 32'(saw_full), 32'd1);
    check("burst_results", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++)
      check("burst_y", 32'(got_q[i]), 32'(burst_y[i]));

    // Output stall with two jobs queued.
    bus.out_ready_i = 1'b0;
    s0 = starts;
    push(8'd7, 8'd8);
    push(8'd14, 8'd8);
    repeat (200) @(posedge clk_i);
    #1;
    check("stall_starts", 32'(starts - s0), 32'd2);
    check("stall_state", 32'(bus.dbg_state), 32'(WAIT));
    check("stall_valid", 32'(bus.out_valid_o), 32'd1);
    check("stall_y", 32'(bus.out_y_o), 32'd3);
    bus.out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("release_valid", 32'(bus.out_valid_o), 32'd1);
    check("release_y", 32'(bus.out_y_o), 32'd4);
    check("release_err", 32'(bus.out_err_o), 32'd0);
    wait_drain(100);

    // Watchdog: busy stuck high, then a normal job follows.
    stuck_mode = 1'b1;
    push(8'd9, 8'd1);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk_i);
      if (bus.acc_start_o) found = 1'b1;
    end
    check("timeout_launch_seen", 32'(found), 32'd1);
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 4 * TIMEOUT && !found; i++) begin
      @(negedge clk_i);
      n++;
      if (n == 1) stuck_mode = 1'b0;
      if (bus.out_valid_o) found = 1'b1;
    end
    check("timeout_latency", 32'(n), 32'(TIMEOUT + 2));
    check("timeout_err_flag", 32'(bus.out_err_o), 32'd1);
    @(posedge clk_i);
    #1;
    push(8'd20, 8'd64);
    wait_drain(100);

    // Randomized traffic with random busy times and consumer stalls.
    stub_lat  = 0;
    push_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk_i);
            #1;
          end
          push(8'($urandom), 8'($urandom));
        end
        push_done = 1'b1;
      end
      begin
        while (!push_done) begin
          @(posedge clk_i);
          #1;
          bus.out_ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready_i = 1'b1;
    wait_drain(500);

    // Asynchronous reset in WAIT with three pairs queued.
    stub_lat = 100;
    push(8'd1, 8'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk_i);
      #1;
      if (bus.dbg_state == WAIT) found = 1'b1;
    end
    check("midrst_in_wait", 32'(found), 32'd1);
    push(8'd2, 8'd2);
    push(8'd3, 8'd3);
    push(8'd4, 8'd4);
    check("midrst_queued", 32'(bus.count_o), 32'd3);
    rst_i = 1'b0;
    model_flush();
    #1;
    check("midrst_start", 32'(bus.acc_start_o), 32'd0);
    check("midrst_acc_a", 32'(bus.acc_a_o), 32'd0);
    check("midrst_acc_b", 32'(bus.acc_b_o), 32'd0);
    check("midrst_valid", 32'(bus.out_valid_o), 32'd0);
    check("midrst_y", 32'(bus.out_y_o), 32'd0);
    check("midrst_err", 32'(bus.out_err_o), 32'd0);
    check("midrst_count", 32'(bus.count_o), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk_i);
      if (bus.out_valid_o || bus.acc_start_o) seen++;
    end
    check("midrst_no_activity", 32'(seen), 32'd0);
    check("midrst_count_after", 32'(bus.count_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard bound on the whole run.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish by %0t", $time);
    $fatal(1, "run did not finish");
  end

endmodule
